// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the arbiter request wrapper.
// Imported by the output FIFO, the top stage and the bench.
package arb_pkg;

    localparam int OUT_FIFO_DEPTH = 2;
    localparam int MAX_N          = 32;
    localparam int MAX_SW         = $clog2(MAX_N);
    localparam int DEF_N          = 4;
    localparam int DEF_W          = 32;

    typedef struct packed {
        logic [$clog2(DEF_N)-1:0] src;
        logic [DEF_W-1:0]         data;
    } fifo_entry_t;

    function automatic logic [MAX_SW-1:0] onehot2idx(
        input logic [MAX_N-1:0] oh
    );
        logic [MAX_SW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_SW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_out_fifo.sv
// Small synchronous FIFO holding granted {src,data} entries.
// Head is presented directly from storage; push at full is legal with a pop.
module arb_out_fifo
    import arb_pkg::*;
#(
    parameter  int EW    = 8,
    parameter  int DEPTH = OUT_FIFO_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [EW-1:0] din_i,
    input  logic          pop_i,
    output logic [EW-1:0] dout_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign cnt_o   = cnt_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= nxt(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= nxt(rptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/arb_req_stage.sv
// Client slots, request generation and grant accept around a round-robin arbiter.
// Accepted grants move the slot payload, tagged with its index, into the output FIFO.
module arb_req_stage
    import arb_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   req,
    input  logic [N-1:0]   grant,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_src,
    output logic           grant_err
);

    localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  data;
    } entry_t;

    logic [N-1:0]  slot_vld_q;
    logic [N-1:0]  slot_vld_d;
    logic [W-1:0]  slot_data_q [N];
    logic [W-1:0]  slot_data_d [N];
    logic [N-1:0]  load;
    logic [N-1:0]  gacc;
    logic          multi;
    logic          has_space;
    logic          req_en;
    logic [CW:0]   credit;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    entry_t        push_e;
    entry_t        head_e;

    assign multi     = |(grant & (grant - N'(1)));
    assign has_space = ~fifo_full;
    assign gacc      = grant & slot_vld_q & {N{has_space & ~multi}};

    assign in_ready = ~slot_vld_q | gacc;
    assign load     = in_valid & in_ready;

    // Grant lands a cycle after req, so count the push happening now.
    assign credit = {1'b0, fifo_cnt} + (CW + 1)'(|gacc);
    assign req_en = credit < (CW + 1)'(OUT_FIFO_DEPTH);
    assign req    = slot_vld_q & ~grant & {N{req_en}};

    assign grant_err = multi
                     | (|(grant & ~slot_vld_q))
                     | ((|(grant & slot_vld_q)) & ~has_space);

    always_comb begin
        slot_vld_d = (slot_vld_q & ~gacc) | load;
        for (int i = 0; i < N; i++) begin
            slot_data_d[i] = load[i] ? in_data[i*W +: W]
                                     : slot_data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= '0;
            for (int i = 0; i < N; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            slot_vld_q <= slot_vld_d;
            for (int i = 0; i < N; i++) begin
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    always_comb begin
        push_e.src  = SW'(onehot2idx(MAX_N'(gacc)));
        push_e.data = '0;
        for (int i = 0; i < N; i++) begin
            push_e.data = push_e.data | (slot_data_q[i] & {W{gacc[i]}});
        end
    end

    arb_out_fifo #(
        .EW    ($bits(entry_t)),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (|gacc),
        .din_i   (push_e),
        .pop_i   (out_valid & out_ready),
        .dout_o  (head_e),
        .cnt_o   (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head_e.data;
    assign out_src   = head_e.src;

endmodule
